// File: rtl/pong_match_ctrl.sv
// Match controller for a two-player pong game: serve countdown, scoring,
// pause handling and win detection, all outputs decoded from registered state.
module pong_match_ctrl #(
  parameter int SCORE_W       = 4,
  parameter int WIN_SCORE     = 7,
  parameter int SERVE_TICKS   = 60,
  parameter int WIN_BY_TWO    = 0,
  parameter int SINGLE_PLAYER = 0
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Tick,
  input  logic               Start,
  input  logic               Pause,
  input  logic               MissLeft,
  input  logic               MissRight,
  output logic [SCORE_W-1:0] ScoreLeft,
  output logic [SCORE_W-1:0] ScoreRight,
  output logic [2:0]         State,
  output logic               BallRun,
  output logic               BallRecenter,
  output logic               ServeDir,
  output logic [1:0]         Winner,
  output logic               GameOver
);

  localparam int CNT_W = $clog2(SERVE_TICKS + 1);
  localparam int EXT_W = SCORE_W + 1;
  localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_TICKS);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
  localparam logic [EXT_W-1:0]   WIN_EXT    = EXT_W'(WIN_SCORE);
  localparam logic [EXT_W-1:0]   LEAD_EXT   = EXT_W'(2);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SERVE  = 3'd1,
    PLAY   = 3'd2,
    PAUSED = 3'd3,
    POINT  = 3'd4,
    OVER   = 3'd5
  } state_t;

  state_t             state, stateNext;
  logic [SCORE_W-1:0] scoreL, scoreLNext;
  logic [SCORE_W-1:0] scoreR, scoreRNext;
  logic [CNT_W-1:0]   cnt, cntNext;
  logic               dir, dirNext;
  logic [1:0]         win, winNext;

  logic               missL, missR;
  logic [EXT_W-1:0]   extL, extR;
  logic               leftWins, rightWins;

  assign missL = MissLeft;
  assign missR = MissRight && (SINGLE_PLAYER == 0);

  // One extra bit keeps "other score + 2" from wrapping at the top of the range.
  assign extL      = {1'b0, scoreL};
  assign extR      = {1'b0, scoreR};
  assign leftWins  = (extL >= WIN_EXT) && ((WIN_BY_TWO == 0) || (extL >= extR + LEAD_EXT));
  assign rightWins = (extR >= WIN_EXT) && ((WIN_BY_TWO == 0) || (extR >= extL + LEAD_EXT));

  // NOTE: reset is sampled on the clock edge only; every register, including the
  // serve counter, has a defined reset value because the outputs decode from them.
  // NOTE: state registers use non-blocking assignments so all of them update
  // together from the values computed in the previous cycle.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= IDLE;
      scoreL <= '0;
      scoreR <= '0;
      cnt    <= '0;
      dir    <= 1'b1;
      win    <= 2'b00;
    end else begin
      state  <= stateNext;
      scoreL <= scoreLNext;
      scoreR <= scoreRNext;
      cnt    <= cntNext;
      dir    <= dirNext;
      win    <= winNext;
    end
  end

  // NOTE: every next-state value defaults to "hold" first so no path infers a latch.
  always_comb begin
    stateNext  = state;
    scoreLNext = scoreL;
    scoreRNext = scoreR;
    cntNext    = cnt;
    dirNext    = dir;
    winNext    = win;

    unique case (state)
      IDLE: begin
        scoreLNext = '0;
        scoreRNext = '0;
        if (Start) begin
          stateNext = SERVE;
          cntNext   = SERVE_LOAD;
        end
      end
      SERVE: begin
        if (Tick) begin
          if (cnt == CNT_W'(1)) stateNext = PLAY;
          if (cnt != '0)        cntNext   = cnt - 1'b1;
        end
      end
      PLAY: begin
        if (missL && missR) begin
          stateNext = SERVE;
          cntNext   = SERVE_LOAD;
        end else if (missL) begin
          if (scoreR != SCORE_MAX) scoreRNext = scoreR + SCORE_W'(1);
          dirNext   = 1'b0;
          stateNext = POINT;
        end else if (missR) begin
          if (scoreL != SCORE_MAX) scoreLNext = scoreL + SCORE_W'(1);
          dirNext   = 1'b1;
          stateNext = POINT;
        end else if (Pause) begin
          stateNext = PAUSED;
        end
      end
      PAUSED: begin
        if (Pause) stateNext = PLAY;
      end
      POINT: begin
        if (leftWins) begin
          stateNext = OVER;
          winNext   = 2'b01;
        end else if (rightWins) begin
          stateNext = OVER;
          winNext   = 2'b10;
        end else begin
          stateNext = SERVE;
          cntNext   = SERVE_LOAD;
        end
      end
      OVER: begin
        if (Start) begin
          scoreLNext = '0;
          scoreRNext = '0;
          winNext    = 2'b00;
          stateNext  = SERVE;
          cntNext    = SERVE_LOAD;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign ScoreLeft    = scoreL;
  assign ScoreRight   = scoreR;
  assign State        = state;
  assign BallRun      = (state == PLAY);
  assign BallRecenter = (state == IDLE) || (state == SERVE);
  assign ServeDir     = dir;
  assign Winner       = win;
  assign GameOver     = (state == OVER);

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Self-checking bench for pong_match_ctrl: four parameterisations, a table of
// vectors plus hand-written sequences, expected values queued per driven cycle.
module tb_pong_match_ctrl;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_SERVE = 3'd1, ST_PLAY = 3'd2,
                         ST_PAUSED = 3'd3, ST_POINT = 3'd4, ST_OVER = 3'd5;

  typedef struct packed {
    logic reset, tick, start, pause, missL, missR;
  } in_t;

  typedef struct packed {
    logic [3:0] sl, sr;
    logic [2:0] st;
    logic       run, rec, dir;
    logic [1:0] win;
    logic       over;
  } out_t;

  typedef struct packed {
    logic [2:0] st;
    logic [3:0] sl, sr;
    logic       dir;
    logic [1:0] win;
  } exp_t;

  typedef struct {
    int   d;
    in_t  in;
    exp_t e;
  } vec_t;

  localparam in_t I_NONE  = 6'b000000;
  localparam in_t I_RST   = 6'b100000;
  localparam in_t I_TICK  = 6'b010000;
  localparam in_t I_START = 6'b001000;
  localparam in_t I_PAUSE = 6'b000100;
  localparam in_t I_ML    = 6'b000010;
  localparam in_t I_MR    = 6'b000001;

  // Per-instance parameters: 0 defaults, 1 win-by-two to 3, 2 narrow scores, 3 single player.
  localparam int SW_P [4] = '{4, 4, 2, 2};
  localparam int WS_P [4] = '{7, 3, 3, 3};
  localparam int ST_P [4] = '{60, 2, 2, 2};
  localparam int W2_P [4] = '{0, 1, 1, 1};
  localparam int SP_P [4] = '{0, 0, 0, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  in_t  drv [4];
  out_t obs [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int SW = SW_P[g];
    logic [SW-1:0] sl, sr;
    logic [2:0]    st;
    logic          run, rec, dir, over;
    logic [1:0]    win;

    pong_match_ctrl #(
      .SCORE_W(SW), .WIN_SCORE(WS_P[g]), .SERVE_TICKS(ST_P[g]),
      .WIN_BY_TWO(W2_P[g]), .SINGLE_PLAYER(SP_P[g])
    ) u_dut (
      .Clock(clk), .Reset(drv[g].reset), .Tick(drv[g].tick), .Start(drv[g].start),
      .Pause(drv[g].pause), .MissLeft(drv[g].missL), .MissRight(drv[g].missR),
      .ScoreLeft(sl), .ScoreRight(sr), .State(st), .BallRun(run),
      .BallRecenter(rec), .ServeDir(dir), .Winner(win), .GameOver(over)
    );

    assign obs[g] = '{sl: 4'(sl), sr: 4'(sr), st: st, run: run, rec: rec,
                      dir: dir, win: win, over: over};
  end

  int   nChecks = 0;
  int   nFails  = 0;
  exp_t expQ[$];
  vec_t tbl[$];

  task automatic check(input int d, input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("FAIL dut%0d %s: got %0d expected %0d at %0t", d, name, act, exp, $time);
    end
  endtask

  function automatic exp_t ex(input logic [2:0] st, input int sl, input int sr,
                              input logic dir, input logic [1:0] win);
    return '{st: st, sl: 4'(sl), sr: 4'(sr), dir: dir, win: win};
  endfunction

  // Drive one cycle of stimulus at the falling edge; compare after the next rising edge.
  task automatic step(input int d, input in_t in, input exp_t e);
    exp_t eq;
    out_t o;
    drv[d] = in;
    expQ.push_back(e);
    @(posedge clk);
    @(negedge clk);
    drv[d] = I_NONE;
    eq = expQ.pop_front();
    o  = obs[d];
    check(d, "State",        o.st,   eq.st);
    check(d, "ScoreLeft",    o.sl,   eq.sl);
    check(d, "ScoreRight",   o.sr,   eq.sr);
    check(d, "ServeDir",     o.dir,  eq.dir);
    check(d, "Winner",       o.win,  eq.win);
    check(d, "BallRun",      o.run,  int'(eq.st == ST_PLAY));
    check(d, "BallRecenter", o.rec,  int'(eq.st == ST_IDLE || eq.st == ST_SERVE));
    check(d, "GameOver",     o.over, int'(eq.st == ST_OVER));
  endtask

  // n Tick pulses from a fresh serve; Start/Pause/Miss are thrown in once and must be ignored.
  task automatic serve(input int d, input int n, input int sl, input int sr, input logic dir);
    for (int k = 1; k <= n; k++) begin
      step(d, I_TICK, ex((k == n) ? ST_PLAY : ST_SERVE, sl, sr, dir, 2'b00));
      step(d, (k == 1 && k < n) ? in_t'(I_START | I_PAUSE | I_ML | I_MR) : I_NONE,
           ex((k == n) ? ST_PLAY : ST_SERVE, sl, sr, dir, 2'b00));
    end
  endtask

  task automatic add(input in_t in, input logic [2:0] st, input int sl, input int sr,
                     input logic dir, input logic [1:0] win);
    tbl.push_back('{d: 1, in: in, e: ex(st, sl, sr, dir, win)});
  endtask

  task automatic addServe(input int sl, input int sr, input logic dir);
    add(I_NONE, ST_SERVE, sl, sr, dir, 2'b00);
    add(I_TICK, ST_SERVE, sl, sr, dir, 2'b00);
    add(I_TICK, ST_PLAY,  sl, sr, dir, 2'b00);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   l, r;
    logic dr;
    for (int i = 0; i < 4; i++) drv[i] = I_NONE;
    @(negedge clk);

    // Defaults: reset, serve countdown, scoring to 7, restart.
    step(0, I_RST, ex(ST_IDLE, 0, 0, 1'b1, 2'b00));
    step(0, in_t'(I_TICK | I_PAUSE | I_ML | I_MR), ex(ST_IDLE, 0, 0, 1'b1, 2'b00));
    step(0, I_START, ex(ST_SERVE, 0, 0, 1'b1, 2'b00));
    serve(0, 60, 0, 0, 1'b1);
    step(0, I_START, ex(ST_PLAY, 0, 0, 1'b1, 2'b00));
    for (int i = 1; i <= 7; i++) begin
      step(0, I_MR, ex(ST_POINT, i, 0, 1'b1, 2'b00));
      if (i < 7) begin
        step(0, I_NONE, ex(ST_SERVE, i, 0, 1'b1, 2'b00));
        serve(0, 60, i, 0, 1'b1);
      end
    end
    step(0, I_NONE, ex(ST_OVER, 7, 0, 1'b1, 2'b01));
    step(0, in_t'(I_TICK | I_PAUSE | I_ML | I_MR), ex(ST_OVER, 7, 0, 1'b1, 2'b01));
    step(0, I_START, ex(ST_SERVE, 0, 0, 1'b1, 2'b00));
    serve(0, 60, 0, 0, 1'b1);

    // Miss beats Pause, then a double miss replays without touching score or direction.
    step(0, in_t'(I_PAUSE | I_ML), ex(ST_POINT, 0, 1, 1'b0, 2'b00));
    step(0, I_NONE, ex(ST_SERVE, 0, 1, 1'b0, 2'b00));
    serve(0, 60, 0, 1, 1'b0);
    step(0, in_t'(I_ML | I_MR), ex(ST_SERVE, 0, 1, 1'b0, 2'b00));
    serve(0, 60, 0, 1, 1'b0);

    // Pause freezes play; reset from PAUSED restores every reset value.
    step(0, I_PAUSE, ex(ST_PAUSED, 0, 1, 1'b0, 2'b00));
    step(0, I_ML, ex(ST_PAUSED, 0, 1, 1'b0, 2'b00));
    step(0, in_t'(I_TICK | I_START | I_MR), ex(ST_PAUSED, 0, 1, 1'b0, 2'b00));
    step(0, I_PAUSE, ex(ST_PLAY, 0, 1, 1'b0, 2'b00));
    step(0, I_PAUSE, ex(ST_PAUSED, 0, 1, 1'b0, 2'b00));
    step(0, in_t'(I_RST | I_PAUSE | I_START), ex(ST_IDLE, 0, 0, 1'b1, 2'b00));

    // Win-by-two to 3: deuce at 3-3, 4-3 continues, 5-3 wins.
    add(I_RST,   ST_IDLE,  0, 0, 1'b1, 2'b00);
    add(I_START, ST_SERVE, 0, 0, 1'b1, 2'b00);
    add(I_TICK,  ST_SERVE, 0, 0, 1'b1, 2'b00);
    add(I_TICK,  ST_PLAY,  0, 0, 1'b1, 2'b00);
    add(I_MR, ST_POINT, 1, 0, 1'b1, 2'b00); addServe(1, 0, 1'b1);
    add(I_ML, ST_POINT, 1, 1, 1'b0, 2'b00); addServe(1, 1, 1'b0);
    add(I_MR, ST_POINT, 2, 1, 1'b1, 2'b00); addServe(2, 1, 1'b1);
    add(I_ML, ST_POINT, 2, 2, 1'b0, 2'b00); addServe(2, 2, 1'b0);
    add(I_MR, ST_POINT, 3, 2, 1'b1, 2'b00); addServe(3, 2, 1'b1);
    add(I_ML, ST_POINT, 3, 3, 1'b0, 2'b00); addServe(3, 3, 1'b0);
    add(I_MR, ST_POINT, 4, 3, 1'b1, 2'b00); addServe(4, 3, 1'b1);
    add(I_MR, ST_POINT, 5, 3, 1'b1, 2'b00);
    add(I_NONE,  ST_OVER,  5, 3, 1'b1, 2'b01);
    add(I_START, ST_SERVE, 0, 0, 1'b1, 2'b00);
    foreach (tbl[i]) step(tbl[i].d, tbl[i].in, tbl[i].e);

    // Reset mid-serve, then a fresh serve must count the full reload again.
    step(1, I_TICK, ex(ST_SERVE, 0, 0, 1'b1, 2'b00));
    step(1, in_t'(I_RST | I_TICK), ex(ST_IDLE, 0, 0, 1'b1, 2'b00));
    step(1, I_START, ex(ST_SERVE, 0, 0, 1'b1, 2'b00));
    serve(1, 2, 0, 0, 1'b1);

    // Two-bit scores: left saturates at 3 with right at 2, never wraps or wins.
    step(2, I_RST, ex(ST_IDLE, 0, 0, 1'b1, 2'b00));
    step(2, I_START, ex(ST_SERVE, 0, 0, 1'b1, 2'b00));
    serve(2, 2, 0, 0, 1'b1);
    l = 0; r = 0; dr = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i < 2) begin
        r  = (r < 3) ? r + 1 : 3;
        dr = 1'b0;
      end else begin
        l  = (l < 3) ? l + 1 : 3;
        dr = 1'b1;
      end
      step(2, (i < 2) ? I_ML : I_MR, ex(ST_POINT, l, r, dr, 2'b00));
      step(2, I_NONE, ex(ST_SERVE, l, r, dr, 2'b00));
      serve(2, 2, l, r, dr);
    end

    // Single player: MissRight has no effect, even alongside MissLeft.
    step(3, I_RST, ex(ST_IDLE, 0, 0, 1'b1, 2'b00));
    step(3, I_START, ex(ST_SERVE, 0, 0, 1'b1, 2'b00));
    serve(3, 2, 0, 0, 1'b1);
    step(3, I_MR, ex(ST_PLAY, 0, 0, 1'b1, 2'b00));
    step(3, I_MR, ex(ST_PLAY, 0, 0, 1'b1, 2'b00));
    step(3, in_t'(I_ML | I_MR), ex(ST_POINT, 0, 1, 1'b0, 2'b00));
    step(3, I_NONE, ex(ST_SERVE, 0, 1, 1'b0, 2'b00));

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/pong_match_ctrl.md
PONG_MATCH_CTRL -- requirements
Module: pong_match_ctrl

Interface
REQ-001 Parameter SCORE_W, default 4: width of each score register.
REQ-002 Parameter WIN_SCORE, default 7: points needed to win; SHALL be 1..2^SCORE_W-1.
REQ-003 Parameter SERVE_TICKS, default 60: Tick pulses spent in SERVE before play; SHALL be >= 1.
REQ-004 Parameter WIN_BY_TWO, default 0: when 1, the winner SHALL also lead by >= 2.
REQ-005 Parameter SINGLE_PLAYER, default 0: when 1, MissRight SHALL be ignored, so only the right score can advance.
REQ-006 Clock  input  1  system clock; all state changes on its rising edge.
REQ-007 Reset  input  1  synchronous, active-high reset.
REQ-008 Tick  input  1  one-Clock-cycle frame strobe from slowClock.
REQ-009 Start  input  1  one-cycle start/restart request.
REQ-010 Pause  input  1  one-cycle pause-toggle request.
REQ-011 MissLeft  input  1  one-cycle pulse: ball passed the left bar.
REQ-012 MissRight  input  1  one-cycle pulse: ball passed the right bar.
REQ-013 ScoreLeft  output  SCORE_W  left player score.
REQ-014 ScoreRight  output  SCORE_W  right player score.
REQ-015 State  output  3  encoded FSM state: IDLE=0, SERVE=1, PLAY=2, PAUSED=3, POINT=4, OVER=5.
REQ-016 BallRun  output  1  ball may move; high only in PLAY.
REQ-017 BallRecenter  output  1  ball held at its start position; high in IDLE and SERVE.
REQ-018 ServeDir  output  1  initial ball direction: 0 = toward left, 1 = toward right.
REQ-019 Winner  output  2  00 none, 01 left, 10 right.
REQ-020 GameOver  output  1  high only in OVER.

Function
REQ-021 All outputs SHALL be registered or decoded from registered state only, with no combinational path from inputs.
REQ-022 IDLE: scores held at 0; Start SHALL move to SERVE and load the serve counter with SERVE_TICKS.
REQ-023 SERVE: counter decrements on each Tick; a Tick with counter==1 SHALL move to PLAY on the next edge; Start, Pause and Miss inputs are ignored.
REQ-024 PLAY: MissLeft alone SHALL increment ScoreRight, set ServeDir=0 and move to POINT.
REQ-025 PLAY: MissRight alone SHALL increment ScoreLeft, set ServeDir=1 and move to POINT.
REQ-026 PLAY: simultaneous MissLeft and MissRight SHALL leave scores and ServeDir unchanged and move to SERVE with the counter reloaded (replay).
REQ-027 PLAY: Pause with no Miss SHALL move to PAUSED; a Miss takes priority over a Pause in the same cycle; Start is ignored.
REQ-028 PAUSED: Pause SHALL return to PLAY; Miss, Start and Tick are ignored; scores are frozen.
REQ-029 POINT lasts exactly one cycle: if the win condition holds, move to OVER and set Winner, otherwise move to SERVE with the counter reloaded.
REQ-030 Win condition: a score >= WIN_SCORE, and when WIN_BY_TWO=1, also >= the other score + 2; left is tested before right.
REQ-031 Scores SHALL saturate at 2^SCORE_W-1 and never wrap.
REQ-032 Score comparison SHALL use SCORE_W+1-bit arithmetic so that +2 cannot overflow.
REQ-033 OVER: Start SHALL clear both scores and Winner, keep ServeDir, and move to SERVE with the counter reloaded; other inputs are ignored.
REQ-034 Latency: a score changes one Clock after its Miss pulse; Winner and GameOver are valid one Clock after POINT is entered.

Reset
REQ-035 Reset SHALL take priority over every input, in any state and including mid-serve or mid-pause.
REQ-036 Reset values: State=IDLE, both scores=0, serve counter=0, ServeDir=1, Winner=00, BallRun=0, BallRecenter=1, GameOver=0.

Verification
REQ-037 Defaults, Reset, Start, then 60 Tick pulses: State=SERVE through Tick 59; State=PLAY and BallRun=1 after Tick 60.
REQ-038 In PLAY, apply MissRight 7 times, serving between each: ScoreLeft goes 1..7, State=POINT then OVER, Winner=01, GameOver=1; a further Start gives scores=0, Winner=00, State=SERVE.
REQ-039 WIN_BY_TWO=1, WIN_SCORE=3, score 3-3, MissRight: 4-3 leads to SERVE; a second MissRight: 5-3 leads to OVER with Winner=01.
REQ-040 In PLAY, MissLeft and MissRight in the same cycle: scores unchanged, State=SERVE, ServeDir unchanged; Pause+MissLeft in the same cycle: ScoreRight+1, State=POINT.
REQ-041 Pause in PLAY: State=PAUSED, BallRun=0, MissLeft ignored; second Pause: State=PLAY; Reset asserted in PAUSED gives all REQ-036 values on the next edge.
REQ-042 SCORE_W=2, WIN_SCORE=3, WIN_BY_TWO=1, SINGLE_PLAYER=0: ScoreLeft saturates at 3 and never wraps; SINGLE_PLAYER=1: MissRight pulses leave ScoreLeft at 0.
